// File: rtl/cba_pipe_addsub.sv
`timescale 1ns/1ps
// cba_pipe_addsub: pipelined carry-bypass adder/subtractor.
//
// Each pipeline stage resolves one SEG-bit slice of the carry chain with
// BLOCK-bit carry-bypass blocks. The carry out of each slice is registered
// and handed to the next stage. The result is in the last stage's registers.
// A valid/ready handshake with full backpressure controls the pipeline.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   operand handshake; in_ready depends only on out_valid/out_ready
//   a, b, cin, sub   operands, carry/borrow-in, 0 = add / 1 = subtract
//   out_valid/ready  result handshake
//   sum, cout, of    result, raw MSB carry (1 = no borrow when subtracting),
//                    signed overflow
module cba_pipe_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned BLOCK  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             of
);

    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned NBLK = SEG / BLOCK;
    localparam int unsigned LAST = STAGES - 1;

    // Reject illegal geometries when the design is elaborated
    if ((STAGES == 0) || (BLOCK == 0) || (WIDTH % (STAGES * BLOCK) != 0)) begin : g_bad_params
        $error("cba_pipe_addsub: WIDTH must be divisible by STAGES*BLOCK");
    end

    // One SEG-bit slice: ripple inside each block, bypass the block carry
    // when every bit of the block propagates. Returns {carry_out, sum}.
    function automatic logic [SEG:0] seg_add(
        input logic [SEG-1:0] x,
        input logic [SEG-1:0] y,
        input logic           ci
    );
        logic [SEG-1:0] s;
        logic           c;
        logic           c_blk;
        logic           p_blk;
        int unsigned    n;
        s = '0;
        c = ci;
        for (int j = 0; j < int'(NBLK); j++) begin
            c_blk = c;
            p_blk = 1'b1;
            for (int i = 0; i < int'(BLOCK); i++) begin
                n     = int'(j) * BLOCK + int'(i);
                s[n]  = x[n] ^ y[n] ^ c;
                c     = (x[n] & y[n]) | (c & (x[n] ^ y[n]));
                p_blk = p_blk & (x[n] ^ y[n]);
            end
            // A fully propagating block passes its carry-in straight through
            c = p_blk ? c_blk : c;
        end
        return {c, s};
    endfunction

    // Stage registers (index k = stage k; LAST holds the visible result)
    logic             v_q    [STAGES];
    logic [WIDTH-1:0] sum_q  [STAGES];
    logic             c_q    [STAGES];
    logic [WIDTH-1:0] a_q    [STAGES];
    logic [WIDTH-1:0] b_q    [STAGES];
    logic             amsb_q [STAGES];
    logic             bmsb_q [STAGES];
    logic             of_q;

    // Per-stage inputs (from ports for stage 0, from stage k-1 otherwise)
    logic             src_v    [STAGES];
    logic [WIDTH-1:0] src_a    [STAGES];
    logic [WIDTH-1:0] src_b    [STAGES];
    logic             src_c    [STAGES];
    logic [WIDTH-1:0] src_sum  [STAGES];
    logic             src_amsb [STAGES];
    logic             src_bmsb [STAGES];
    logic [WIDTH-1:0] nxt_sum  [STAGES];
    logic             nxt_c    [STAGES];
    logic             nxt_of;
    logic [WIDTH-1:0] b_eff;
    logic             en;

    // Stage sources and slice arithmetic
    always_comb begin
        en       = !v_q[LAST] || out_ready;
        b_eff    = sub ? ~b : b;
        src_v    = '{default: 1'b0};
        src_a    = '{default: '0};
        src_b    = '{default: '0};
        src_c    = '{default: 1'b0};
        src_sum  = '{default: '0};
        src_amsb = '{default: 1'b0};
        src_bmsb = '{default: 1'b0};
        nxt_sum  = '{default: '0};
        nxt_c    = '{default: 1'b0};

        // Subtraction is a + ~b + ~cin; the borrow-in becomes an inverted carry
        src_v[0]    = in_valid;
        src_a[0]    = a;
        src_b[0]    = b_eff;
        src_c[0]    = cin ^ sub;
        src_amsb[0] = a[WIDTH-1];
        src_bmsb[0] = b_eff[WIDTH-1];

        for (int k = 1; k < int'(STAGES); k++) begin
            src_v[k]    = v_q[k-1];
            src_a[k]    = a_q[k-1];
            src_b[k]    = b_q[k-1];
            src_c[k]    = c_q[k-1];
            src_sum[k]  = sum_q[k-1];
            src_amsb[k] = amsb_q[k-1];
            src_bmsb[k] = bmsb_q[k-1];
        end

        for (int k = 0; k < int'(STAGES); k++) begin
            nxt_sum[k] = src_sum[k];
            {nxt_c[k], nxt_sum[k][int'(k) * SEG +: SEG]} =
                seg_add(src_a[k][int'(k) * SEG +: SEG], src_b[k][int'(k) * SEG +: SEG], src_c[k]);
        end

        nxt_of = (src_amsb[LAST] == src_bmsb[LAST]) && (nxt_sum[LAST][WIDTH-1] != src_amsb[LAST]);
    end

    // Pipeline registers: whole pipe advances on en, data loads only for valid
    // entries so the outputs keep the last valid result across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                v_q[k] <= 1'b0;
            end
            sum_q[LAST] <= '0;
            c_q[LAST]   <= 1'b0;
            of_q        <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                v_q[k] <= src_v[k];
                if (src_v[k]) begin
                    sum_q[k]  <= nxt_sum[k];
                    c_q[k]    <= nxt_c[k];
                    a_q[k]    <= src_a[k];
                    b_q[k]    <= src_b[k];
                    amsb_q[k] <= src_amsb[k];
                    bmsb_q[k] <= src_bmsb[k];
                end
            end
            if (src_v[LAST]) begin
                of_q <= nxt_of;
            end
        end
    end

    assign in_ready  = en;
    assign out_valid = v_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = c_q[LAST];
    assign of        = of_q;

endmodule
